// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle core: FSM states, trap causes,
// load/store size encodings and small decode helpers.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_EXEC,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_TRAP
  } state_t;

  localparam logic [1:0] CAUSE_ILLEGAL        = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN_FETCH = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN_LS    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT        = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // Byte-enable pattern for an access of the given size, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  size_mask = 8'h01;
      SIZE_H:  size_mask = 8'h03;
      SIZE_W:  size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  // An access is misaligned when its low address bits are not a multiple of its
  // size; doubleword accesses are also rejected outright on a 32-bit core.
  function automatic logic ls_misaligned(input logic [1:0] size,
                                         input logic [2:0] low,
                                         input logic       d_legal);
    case (size)
      SIZE_H:  ls_misaligned = low[0];
      SIZE_W:  ls_misaligned = |low[1:0];
      SIZE_D:  ls_misaligned = (|low) || !d_legal;
      default: ls_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load/store lane handling: byte enables, store-data replication across lanes,
// and extraction plus sign/zero extension of load data.
module lsu_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                 size,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic                       is_unsigned,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN/8-1:0]          be,
  output logic [XLEN-1:0]            wdata_rep,
  output logic [XLEN-1:0]            load_data
);

  localparam int NB = XLEN / 8;

  logic [7:0]      mask8;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  // Shift the size mask into the lanes addressed by the low address bits.
  always_comb begin
    mask8 = size_mask(size);
    be    = NB'(mask8) << offset;
  end

  // Each byte lane carries the store byte it would hold at its own offset, so
  // the memory picks the right bytes whatever lane the access lands on.
  for (genvar i = 0; i < NB; i++) begin : g_rep
    assign wdata_rep[8*i +: 8] = (size == SIZE_B) ? wdata[7:0] :
                                 (size == SIZE_H) ? wdata[8*(i%2) +: 8] :
                                 (size == SIZE_W) ? wdata[8*(i%4) +: 8] :
                                                    wdata[8*i +: 8];
  end

  // Bring the addressed lane down to bit 0 and extend it to the full width.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SIZE_B: begin
        keep = XLEN'(8'hFF);
        sign = shifted[7];
      end
      SIZE_H: begin
        keep = XLEN'(16'hFFFF);
        sign = shifted[15];
      end
      SIZE_W: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        keep = '1;
        sign = shifted[XLEN-1];
      end
    endcase
    load_data = (is_unsigned || !sign) ? (shifted & keep) : (shifted | ~keep);
  end

endmodule

// File: rtl/core_mc.sv
// Multicycle core sequencer: fetch, execute and memory phases over
// valid/gnt/rvalid buses, with PC, instruction latch, lane alignment and traps.
module core_mc
  import core_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_o,
  output logic [XLEN-1:0]     imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [31:0]         imem_rdata_i,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic [XLEN/8-1:0]   dmem_be_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i,
  output logic [31:0]         instr_o,
  output logic                instr_valid_o,
  output logic [XLEN-1:0]     pc_o,
  input  logic [XLEN-1:0]     pc_next_i,
  input  logic                ld_i,
  input  logic                st_i,
  input  logic [XLEN-1:0]     ls_addr_i,
  input  logic [XLEN-1:0]     ls_wdata_i,
  input  logic [1:0]          ls_size_i,
  input  logic                ls_unsigned_i,
  input  logic                illegal_i,
  input  logic                exu_wen_i,
  output logic                reg_wen_o,
  output logic [XLEN-1:0]     load_data_o,
  output logic                load_valid_o,
  output logic                retire_o,
  output logic                halted_o,
  output logic [1:0]          trap_cause_o
);

  localparam int OW = $clog2(XLEN / 8);

  state_t                state, state_next;
  logic [XLEN-1:0]       pc;
  logic [31:0]           instr;
  logic [TIMEOUT_W-1:0]  wd;
  logic [1:0]            trap_cause, cause_next;
  logic                  capture, stalled, mem_op;
  logic [XLEN-1:0]       mem_addr, mem_wdata, mem_pc;
  logic [1:0]            mem_size;
  logic                  mem_uns, mem_ld;

  assign mem_op = ld_i || st_i;

  // Next-state, trap selection and single-cycle pulses for the current phase.
  always_comb begin
    state_next    = state;
    cause_next    = trap_cause;
    capture       = 1'b0;
    retire_o      = 1'b0;
    reg_wen_o     = 1'b0;
    load_valid_o  = 1'b0;
    case (state)
      ST_IDLE: state_next = ST_FETCH_REQ;
      ST_FETCH_REQ: begin
        if (imem_gnt_i) begin
          state_next = ST_FETCH_WAIT;
        end else if (&wd) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          state_next = ST_EXEC;
        end else if (&wd) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_EXEC: begin
        if (illegal_i) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (mem_op && ls_misaligned(ls_size_i, ls_addr_i[2:0], XLEN == 64)) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_MISALIGN_LS;
        end else if (mem_op) begin
          state_next = ST_MEM_REQ;
          capture    = 1'b1;
        end else if (pc_next_i[1:0] != 2'b00) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_MISALIGN_FETCH;
        end else begin
          state_next = ST_FETCH_REQ;
          retire_o   = 1'b1;
          reg_wen_o  = exu_wen_i;
        end
      end
      ST_MEM_REQ: begin
        if (dmem_gnt_i) begin
          state_next = ST_MEM_WAIT;
        end else if (&wd) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          state_next   = ST_FETCH_REQ;
          retire_o     = 1'b1;
          reg_wen_o    = mem_ld;
          load_valid_o = mem_ld;
        end else if (&wd) begin
          state_next = ST_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      default: state_next = ST_TRAP;
    endcase
    stalled = (state == ST_FETCH_REQ || state == ST_FETCH_WAIT ||
               state == ST_MEM_REQ   || state == ST_MEM_WAIT) && (state_next == state);
  end

  // State, PC, instruction latch, watchdog and captured load/store operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      instr      <= NOP_INSTR;
      wd         <= '0;
      trap_cause <= CAUSE_ILLEGAL;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_pc     <= '0;
      mem_size   <= SIZE_B;
      mem_uns    <= 1'b0;
      mem_ld     <= 1'b0;
    end else begin
      state <= state_next;
      wd    <= stalled ? wd + 1'b1 : '0;
      if (state == ST_FETCH_WAIT && imem_rvalid_i) instr <= imem_rdata_i;
      if (capture) begin
        mem_addr  <= ls_addr_i;
        mem_wdata <= ls_wdata_i;
        mem_pc    <= pc_next_i;
        mem_size  <= ls_size_i;
        mem_uns   <= ls_unsigned_i;
        mem_ld    <= ld_i;
      end
      if (state == ST_EXEC && state_next == ST_FETCH_REQ) pc <= pc_next_i;
      if (state == ST_MEM_WAIT && state_next == ST_FETCH_REQ) pc <= mem_pc;
      if (state_next == ST_TRAP && state != ST_TRAP) trap_cause <= cause_next;
    end
  end

  lsu_align #(.XLEN(XLEN)) u_lsu_align (
    .size        (mem_size),
    .offset      (mem_addr[OW-1:0]),
    .is_unsigned (mem_uns),
    .wdata       (mem_wdata),
    .rdata       (dmem_rdata_i),
    .be          (dmem_be_o),
    .wdata_rep   (dmem_wdata_o),
    .load_data   (load_data_o)
  );

  assign imem_req_o    = (state == ST_FETCH_REQ);
  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign instr_o       = instr;
  assign instr_valid_o = (state == ST_EXEC);
  assign dmem_req_o    = (state == ST_MEM_REQ);
  assign dmem_we_o     = !mem_ld;
  assign dmem_addr_o   = {mem_addr[XLEN-1:OW], {OW{1'b0}}};
  assign halted_o      = (state == ST_TRAP);
  assign trap_cause_o  = trap_cause;

endmodule

// File: tb/tb_core_mc.sv
// Directed bench for core_mc: reset, fetch/execute timing, load/store lane
// handling, trap causes, bus watchdog and asynchronous reset abort.
module tb_core_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] instr_o, pc_o, pc_next_i, ls_addr_i, ls_wdata_i, load_data_o;
  logic        instr_valid_o, ld_i, st_i, ls_unsigned_i, illegal_i, exu_wen_i;
  logic [1:0]  ls_size_i, trap_cause_o;
  logic        reg_wen_o, load_valid_o, retire_o, halted_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  core_mc #(.XLEN(32), .RESET_PC(32'h80), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .pc_o(pc_o), .pc_next_i(pc_next_i),
    .ld_i(ld_i), .st_i(st_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_size_i(ls_size_i), .ls_unsigned_i(ls_unsigned_i), .illegal_i(illegal_i),
    .exu_wen_i(exu_wen_i), .reg_wen_o(reg_wen_o), .load_data_o(load_data_o),
    .load_valid_o(load_valid_o), .retire_o(retire_o), .halted_o(halted_o),
    .trap_cause_o(trap_cause_o)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case a handshake never completes.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input logic uns, input logic ill, input logic [31:0] pcn,
                               input logic wen);
    ld_i = ld; st_i = st; ls_addr_i = addr; ls_wdata_i = wdata; ls_size_i = size;
    ls_unsigned_i = uns; illegal_i = ill; pc_next_i = pcn; exu_wen_i = wen;
  endtask

  // Entered at a negedge in FETCH_REQ; returns at the negedge inside EXEC.
  task automatic doFetch(input logic [31:0] word);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = word;
    tick();
    imem_rvalid_i = 1'b0;
  endtask

  // Reset pulse; returns at the negedge after the core has entered FETCH_REQ.
  task automatic doReset();
    rst_n = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    checkOutput("rst_pc",      64'(pc_o),          64'h80);
    checkOutput("rst_instr",   64'(instr_o),       64'h13);
    checkOutput("rst_imemreq", 64'(imem_req_o),    64'h0);
    checkOutput("rst_dmemreq", 64'(dmem_req_o),    64'h0);
    checkOutput("rst_halted",  64'(halted_o),      64'h0);
    checkOutput("rst_cause",   64'(trap_cause_o),  64'h0);
    checkOutput("rst_retire",  64'(retire_o),      64'h0);

    // Release: one IDLE cycle, then fetch request at RESET_PC.
    rst_n = 1'b1;
    #1;
    checkOutput("idle_req", 64'(imem_req_o), 64'h0);
    tick();
    checkOutput("fetch_req",  64'(imem_req_o),  64'h1);
    checkOutput("fetch_addr", 64'(imem_addr_o), 64'h80);

    // ADDI with zero wait states: back to FETCH_REQ three cycles after the first.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h84, 1);
    doFetch(32'h0010_0093);
    checkOutput("addi_ivalid", 64'(instr_valid_o), 64'h1);
    checkOutput("addi_instr",  64'(instr_o),       64'h0010_0093);
    checkOutput("addi_retire", 64'(retire_o),      64'h1);
    checkOutput("addi_wen",    64'(reg_wen_o),     64'h1);
    tick();
    checkOutput("addi_pc",     64'(pc_o),          64'h84);
    checkOutput("addi_req",    64'(imem_req_o),    64'h1);
    checkOutput("addi_noret",  64'(retire_o),      64'h0);

    // LB from 0x1003, top byte 0x80 sign-extends.
    applyStimulus(1, 0, 32'h1003, 0, 2'd0, 0, 0, 32'h88, 1);
    doFetch(32'h0030_0083);
    checkOutput("lb_exec_ret", 64'(retire_o),  64'h0);
    checkOutput("lb_exec_wen", 64'(reg_wen_o), 64'h0);
    tick();
    checkOutput("lb_dreq",  64'(dmem_req_o),  64'h1);
    checkOutput("lb_daddr", 64'(dmem_addr_o), 64'h1000);
    checkOutput("lb_be",    64'(dmem_be_o),   64'h8);
    checkOutput("lb_we",    64'(dmem_we_o),   64'h0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    checkOutput("lb_dreq_off", 64'(dmem_req_o), 64'h0);
    applyStimulus(0, 0, 32'hFFFF_FFFF, 0, 2'd3, 1, 0, 32'h4, 0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h80AB_CDEF;
    #1;
    checkOutput("lb_lvalid", 64'(load_valid_o), 64'h1);
    checkOutput("lb_data",   64'(load_data_o),  64'hFFFF_FF80);
    checkOutput("lb_wen",    64'(reg_wen_o),    64'h1);
    checkOutput("lb_retire", 64'(retire_o),     64'h1);
    tick();
    dmem_rvalid_i = 1'b0;
    checkOutput("lb_pc", 64'(pc_o), 64'h88);

    // LBU from the same lane zero-extends.
    applyStimulus(1, 0, 32'h1003, 0, 2'd0, 1, 0, 32'h8C, 0);
    doFetch(32'h0030_4083);
    tick();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    #1;
    checkOutput("lbu_data", 64'(load_data_o), 64'h80);
    tick();
    dmem_rvalid_i = 1'b0;
    checkOutput("lbu_pc", 64'(pc_o), 64'h8C);

    // SH to 0x2002 with one grant wait state.
    applyStimulus(0, 1, 32'h2002, 32'h1234_BEEF, 2'd1, 0, 0, 32'h90, 1);
    doFetch(32'h0011_1123);
    checkOutput("sh_exec_wen", 64'(reg_wen_o), 64'h0);
    tick();
    checkOutput("sh_dreq",  64'(dmem_req_o),   64'h1);
    checkOutput("sh_we",    64'(dmem_we_o),    64'h1);
    checkOutput("sh_be",    64'(dmem_be_o),    64'hC);
    checkOutput("sh_wdata", 64'(dmem_wdata_o), 64'hBEEF_BEEF);
    checkOutput("sh_daddr", 64'(dmem_addr_o),  64'h2000);
    tick();
    checkOutput("sh_dreq_hold",  64'(dmem_req_o),  64'h1);
    checkOutput("sh_daddr_hold", 64'(dmem_addr_o), 64'h2000);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    #1;
    checkOutput("sh_retire", 64'(retire_o),     64'h1);
    checkOutput("sh_wen",    64'(reg_wen_o),    64'h0);
    checkOutput("sh_lvalid", 64'(load_valid_o), 64'h0);
    tick();
    dmem_rvalid_i = 1'b0;
    checkOutput("sh_pc", 64'(pc_o), 64'h90);

    // Misaligned LW traps with cause 2, no bus request.
    applyStimulus(1, 0, 32'h1002, 0, 2'd2, 0, 0, 32'h94, 1);
    doFetch(32'h0020_2083);
    checkOutput("lw_exec_ret", 64'(retire_o),  64'h0);
    checkOutput("lw_exec_wen", 64'(reg_wen_o), 64'h0);
    tick();
    checkOutput("lw_dreq",   64'(dmem_req_o),   64'h0);
    checkOutput("lw_halted", 64'(halted_o),     64'h1);
    checkOutput("lw_cause",  64'(trap_cause_o), 64'h2);
    tick();
    checkOutput("lw_ireq",   64'(imem_req_o),   64'h0);
    checkOutput("lw_pc",     64'(pc_o),         64'h90);

    // Misaligned next PC traps with cause 1.
    doReset();
    checkOutput("rst2_halted", 64'(halted_o), 64'h0);
    checkOutput("rst2_pc",     64'(pc_o),     64'h80);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h86, 1);
    doFetch(32'h0000_0013);
    checkOutput("mf_wen", 64'(reg_wen_o), 64'h0);
    tick();
    checkOutput("mf_halted", 64'(halted_o),     64'h1);
    checkOutput("mf_cause",  64'(trap_cause_o), 64'h1);

    // Illegal wins over misaligned load and misaligned next PC.
    doReset();
    checkOutput("rst3_cause", 64'(trap_cause_o), 64'h0);
    applyStimulus(1, 0, 32'h1002, 0, 2'd2, 0, 1, 32'h86, 1);
    doFetch(32'hFFFF_FFFF);
    checkOutput("ill_wen",    64'(reg_wen_o), 64'h0);
    checkOutput("ill_retire", 64'(retire_o),  64'h0);
    tick();
    checkOutput("ill_halted", 64'(halted_o),     64'h1);
    checkOutput("ill_cause",  64'(trap_cause_o), 64'h0);

    // Fetch grant never comes: watchdog trap.
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h84, 1);
    for (int i = 0; i < 200; i++) tick();
    checkOutput("wd_early_halt", 64'(halted_o),   64'h0);
    checkOutput("wd_early_req",  64'(imem_req_o), 64'h1);
    cycles = 200;
    while (!halted_o && cycles < 400) begin
      tick();
      cycles++;
    end
    checkOutput("wd_latency", 64'(cycles >= 255 && cycles <= 256), 64'h1);
    checkOutput("wd_cause",   64'(trap_cause_o), 64'h3);
    checkOutput("wd_req",     64'(imem_req_o),   64'h0);

    // Async reset drops a pending request at once and restarts at RESET_PC.
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'hA0, 1);
    doFetch(32'h0000_0013);
    tick();
    checkOutput("ab_pc",  64'(pc_o),       64'hA0);
    checkOutput("ab_req", 64'(imem_req_o), 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("ab_req_drop", 64'(imem_req_o), 64'h0);
    checkOutput("ab_pc_rst",   64'(pc_o),       64'h80);
    tick();
    rst_n = 1'b1;
    tick();
    // rvalid while still requesting must be ignored.
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h1234_5678;
    tick();
    imem_rvalid_i = 1'b0;
    checkOutput("rv_in_req_hold",  64'(imem_req_o), 64'h1);
    checkOutput("rv_in_req_instr", 64'(instr_o),    64'h13);
    checkOutput("ab2_addr", 64'(imem_addr_o), 64'h80);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    checkOutput("ab2_wait_req", 64'(imem_req_o), 64'h0);
    rst_n         = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    checkOutput("ab2_instr", 64'(instr_o), 64'h13);
    tick();
    imem_rvalid_i = 1'b0;
    rst_n = 1'b1;
    tick();
    checkOutput("ab2_restart_req",   64'(imem_req_o),  64'h1);
    checkOutput("ab2_restart_addr",  64'(imem_addr_o), 64'h80);
    checkOutput("ab2_restart_instr", 64'(instr_o),     64'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
